// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued ALU ops until both operands are known,
// dispatches the lowest-index ready entry each cycle and registers its result for the CDB.
module alu_rs #(
  parameter int RS_SIZE = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_alu_op,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qj_valid,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qk_valid,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [4:0]       alu_op,
  input  logic [31:0]      alu_result,
  output logic             alu_fire,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_value
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      vj;
    logic             qj_valid;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vk;
    logic             qk_valid;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
  } entry_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] ready;
  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];

  logic               out_valid_q, out_valid_d;
  logic [TAG_W-1:0]   out_tag_q,   out_tag_d;
  logic [31:0]        out_value_q, out_value_d;

  logic               disp_found, free_found;
  logic [IDX_W-1:0]   disp_idx,   free_idx;
  logic               j_hit, k_hit;
  entry_t             issue_ent;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy_q[i] & ~ent_q[i].qj_valid & ~ent_q[i].qk_valid;
    end
  end

  // Scanning downwards lets the lowest matching index win.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_ready = free_found;
  assign alu_fire    = disp_found;
  assign alu_op1     = disp_found ? ent_q[disp_idx].vj : '0;
  assign alu_op2     = disp_found ? ent_q[disp_idx].vk : '0;
  assign alu_op      = disp_found ? ent_q[disp_idx].op : '0;
  assign out_valid   = out_valid_q;
  assign out_tag     = out_tag_q;
  assign out_value   = out_value_q;

  // An operand whose producer is broadcasting right now is taken straight from the CDB.
  always_comb begin
    j_hit              = issue_qj_valid && cdb_valid && (issue_qj == cdb_tag);
    k_hit              = issue_qk_valid && cdb_valid && (issue_qk == cdb_tag);
    issue_ent.op       = issue_alu_op;
    issue_ent.vj       = j_hit ? cdb_value : issue_vj;
    issue_ent.qj_valid = issue_qj_valid && !j_hit;
    issue_ent.qj       = issue_qj;
    issue_ent.vk       = k_hit ? cdb_value : issue_vk;
    issue_ent.qk_valid = issue_qk_valid && !k_hit;
    issue_ent.qk       = issue_qk;
    issue_ent.dest     = issue_dest;
  end

  always_comb begin
    busy_d      = busy_q;
    ent_d       = ent_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_value_d = out_value_q;

    if (rdy_in) begin
      if (flush_in) begin
        busy_d      = '0;
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = disp_found;
        if (disp_found) begin
          out_tag_d        = ent_q[disp_idx].dest;
          out_value_d      = alu_result;
          busy_d[disp_idx] = 1'b0;
        end

        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && cdb_valid) begin
            if (ent_q[i].qj_valid && ent_q[i].qj == cdb_tag) begin
              ent_d[i].vj       = cdb_value;
              ent_d[i].qj_valid = 1'b0;
            end
            if (ent_q[i].qk_valid && ent_q[i].qk == cdb_tag) begin
              ent_d[i].vk       = cdb_value;
              ent_d[i].qk_valid = 1'b0;
            end
          end
        end

        // free_idx comes from busy_q, so a slot freed by this cycle's dispatch is never picked.
        if (issue_valid && free_found) begin
          ent_d[free_idx]  = issue_ent;
          busy_d[free_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_value_q <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_value_q <= out_value_d;
    end
  end

  // NOTE: entry payload is qualified by busy_q, so it carries no reset and stays plain storage.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios followed by random traffic,
// compared every cycle against a behavioural model of the reservation station.
module tb_alu_rs;

  localparam int RS    = 4;
  localparam int TAG_W = 4;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_BEQ = 5'd5;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             rdy_in = 1'b1;
  logic             flush_in = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_ready;
  logic [4:0]       issue_alu_op = '0;
  logic [31:0]      issue_vj = '0;
  logic             issue_qj_valid = 1'b0;
  logic [TAG_W-1:0] issue_qj = '0;
  logic [31:0]      issue_vk = '0;
  logic             issue_qk_valid = 1'b0;
  logic [TAG_W-1:0] issue_qk = '0;
  logic [TAG_W-1:0] issue_dest = '0;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [31:0]      cdb_value = '0;
  logic [31:0]      alu_op1, alu_op2, alu_result;
  logic [4:0]       alu_op;
  logic             alu_fire;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_value;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_BEQ:  return {31'b0, a == b};
      default: return 32'h0;
    endcase
  endfunction

  // Combinational ALU sitting on the far side of the interface.
  assign alu_result = alu_fn(alu_op, alu_op1, alu_op2);

  alu_rs #(.RS_SIZE(RS), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_alu_op(issue_alu_op),
    .issue_vj(issue_vj), .issue_qj_valid(issue_qj_valid), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_qk_valid(issue_qk_valid), .issue_qk(issue_qk),
    .issue_dest(issue_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op), .alu_result(alu_result),
    .alu_fire(alu_fire), .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit        busy;
    bit [4:0]  op;
    bit [31:0] vj, vk;
    bit        wj, wk;
    bit [3:0]  tj, tk, dest;
  } slot_t;

  slot_t     m [RS];
  bit        m_ov;
  bit [3:0]  m_ot;
  bit [31:0] m_oval;

  function automatic int first_ready();
    for (int i = 0; i < RS; i++)
      if (m[i].busy && !m[i].wj && !m[i].wk) return i;
    return -1;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < RS; i++)
      if (!m[i].busy) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m[i].busy = 0;
    m_ov = 0; m_ot = 0; m_oval = 0;
  endtask

  task automatic model_step();
    int r, f;
    bit was_busy [RS];
    if (!rdy_in) return;
    if (flush_in) begin
      for (int i = 0; i < RS; i++) m[i].busy = 0;
      m_ov = 0;
      return;
    end
    r = first_ready();
    f = first_free();
    for (int i = 0; i < RS; i++) was_busy[i] = m[i].busy;
    m_ov = (r >= 0);
    if (r >= 0) begin
      m_ot   = m[r].dest;
      m_oval = alu_fn(m[r].op, m[r].vj, m[r].vk);
      m[r].busy = 0;
    end
    if (cdb_valid) begin
      for (int i = 0; i < RS; i++) begin
        if (was_busy[i] && m[i].wj && m[i].tj == cdb_tag) begin m[i].vj = cdb_value; m[i].wj = 0; end
        if (was_busy[i] && m[i].wk && m[i].tk == cdb_tag) begin m[i].vk = cdb_value; m[i].wk = 0; end
      end
    end
    if (issue_valid && f >= 0) begin
      m[f].busy = 1;
      m[f].op   = issue_alu_op;
      m[f].dest = issue_dest;
      m[f].tj   = issue_qj;
      m[f].tk   = issue_qk;
      m[f].wj   = issue_qj_valid && !(cdb_valid && issue_qj == cdb_tag);
      m[f].wk   = issue_qk_valid && !(cdb_valid && issue_qk == cdb_tag);
      m[f].vj   = (issue_qj_valid && !m[f].wj) ? cdb_value : issue_vj;
      m[f].vk   = (issue_qk_valid && !m[f].wk) ? cdb_value : issue_vk;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    int r;
    r = first_ready();
    check({where, ".issue_ready"}, 32'(issue_ready), 32'(first_free() >= 0));
    check({where, ".alu_fire"},    32'(alu_fire),    32'(r >= 0));
    check({where, ".alu_op1"},     alu_op1,          (r >= 0) ? m[r].vj : 32'h0);
    check({where, ".alu_op2"},     alu_op2,          (r >= 0) ? m[r].vk : 32'h0);
    check({where, ".alu_op"},      32'(alu_op),      (r >= 0) ? 32'(m[r].op) : 32'h0);
    check({where, ".out_valid"},   32'(out_valid),   32'(m_ov));
    check({where, ".out_tag"},     32'(out_tag),     32'(m_ot));
    check({where, ".out_value"},   out_value,        m_oval);
  endtask

  task automatic cycle(input string where);
    model_step();
    @(posedge clk_in);
    #1;
    check_all(where);
  endtask

  task automatic idle();
    issue_valid = 0; issue_qj_valid = 0; issue_qk_valid = 0;
    cdb_valid = 0; flush_in = 0; rdy_in = 1;
  endtask

  task automatic drive_issue(input logic [4:0] op, input logic [31:0] vj, input logic wj, input logic [3:0] tj,
                             input logic [31:0] vk, input logic wk, input logic [3:0] tk, input logic [3:0] dest);
    issue_valid = 1; issue_alu_op = op;
    issue_vj = vj; issue_qj_valid = wj; issue_qj = tj;
    issue_vk = vk; issue_qk_valid = wk; issue_qk = tk;
    issue_dest = dest;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_in = 1;

    // ADD 5+7 -> tag 3
    drive_issue(OP_ADD, 5, 0, 0, 7, 0, 0, 3);
    cycle("add_issue");
    check("add_fire", 32'(alu_fire), 1);
    idle();
    cycle("add_result");
    check("add_val", out_value, 12);
    check("add_tag", 32'(out_tag), 3);
    check("add_irdy", 32'(issue_ready), 1);

    // SUB waiting on tag 6, woken three cycles later
    drive_issue(OP_SUB, 0, 1, 6, 10, 0, 0, 2);
    cycle("sub_issue");
    idle();
    for (int i = 0; i < 3; i++) cycle("sub_wait");
    check("sub_nofire", 32'(alu_fire), 0);
    cdb_valid = 1; cdb_tag = 6; cdb_value = 25;
    cycle("sub_capture");
    check("sub_fire", 32'(alu_fire), 1);
    idle();
    cycle("sub_result");
    check("sub_val", out_value, 15);
    check("sub_tag", 32'(out_tag), 2);

    // Issue-time bypass of both operands from tag 9
    drive_issue(OP_ADD, 0, 1, 9, 0, 1, 9, 7);
    cdb_valid = 1; cdb_tag = 9; cdb_value = 4;
    cycle("byp_issue");
    check("byp_fire", 32'(alu_fire), 1);
    idle();
    cycle("byp_result");
    check("byp_val", out_value, 8);

    // Fill all entries on tag 1, then release them with one broadcast
    for (int i = 0; i < RS; i++) begin
      drive_issue(OP_ADD, 0, 1, 1, 32'(i), 0, 0, 4'(10 + i));
      cycle("fill");
    end
    check("full_irdy", 32'(issue_ready), 0);
    drive_issue(OP_SUB, 99, 0, 0, 1, 0, 0, 15);
    cycle("full_ignored");
    idle();
    cdb_valid = 1; cdb_tag = 1; cdb_value = 100;
    cycle("full_release");
    idle();
    for (int i = 0; i < RS; i++) begin
      cycle("drain");
      check("drain_valid", 32'(out_valid), 1);
      check("drain_tag", 32'(out_tag), 32'(10 + i));
      check("drain_val", out_value, 32'(100 + i));
    end
    cycle("drain_done");
    check("empty_valid", 32'(out_valid), 0);

    // Pause with one ready entry
    drive_issue(OP_ADD, 20, 0, 0, 22, 0, 0, 5);
    cycle("pause_issue");
    idle();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      cycle("paused");
      check("paused_op1", alu_op1, 20);
      check("paused_valid", 32'(out_valid), 0);
    end
    rdy_in = 1;
    cycle("resume");
    check("resume_val", out_value, 42);
    cycle("resume_once");
    check("resume_once", 32'(out_valid), 0);

    // Flush with three waiting entries and a pending broadcast
    for (int i = 0; i < 3; i++) begin
      drive_issue(OP_XOR, 1, 1, 2, 3, 0, 0, 4'(i));
      cycle("flush_fill");
    end
    drive_issue(OP_OR, 8, 0, 0, 1, 0, 0, 12);
    cycle("flush_ready");
    idle();
    cycle("flush_pending");
    check("flush_pre_valid", 32'(out_valid), 1);
    flush_in = 1;
    drive_issue(OP_ADD, 1, 0, 0, 1, 0, 0, 9);
    cycle("flush");
    check("flush_valid", 32'(out_valid), 0);
    check("flush_irdy", 32'(issue_ready), 1);
    check("flush_fire", 32'(alu_fire), 0);
    idle();

    // Asynchronous reset in the middle of a cycle
    drive_issue(OP_ADD, 1, 1, 3, 2, 0, 0, 4);
    cycle("rst_fill");
    drive_issue(OP_ADD, 1, 0, 0, 2, 0, 0, 6);
    cycle("rst_fill2");
    idle();
    cycle("rst_pending");
    #2 rst_in = 0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_valid", 32'(out_valid), 0);
    #1 rst_in = 1;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      issue_valid    = ($urandom_range(0, 2) != 0);
      issue_alu_op   = 5'($urandom_range(0, 5));
      issue_vj       = $urandom;
      issue_vk       = ($urandom_range(0, 3) == 0) ? issue_vj : $urandom;
      issue_qj_valid = $urandom_range(0, 1);
      issue_qk_valid = $urandom_range(0, 1);
      issue_qj       = 4'($urandom_range(0, 3));
      issue_qk       = 4'($urandom_range(0, 3));
      issue_dest     = 4'($urandom);
      cdb_valid      = $urandom_range(0, 1);
      cdb_tag        = 4'($urandom_range(0, 3));
      cdb_value      = $urandom;
      rdy_in         = ($urandom_range(0, 9) != 0);
      flush_in       = ($urandom_range(0, 39) == 0);
      cycle("rand");
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- ALU reservation station for the out-of-order core; the initiator side of the ALU interface.
- Holds issued ALU instructions until both operands are available, snooping the CDB for missing values.
- Each cycle it drives the lowest-index ready entry into the combinational ALU, then registers the ALU result as a one-cycle broadcast to the CDB/ROB arbiter.

Parameters:
RS_SIZE, 4, number of entries (power of 2, 2..16)
TAG_W, 4, ROB tag width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-low
rdy_in  input  1  pause when low: all state holds, issue ignored
flush_in  input  1  synchronous clear (misprediction)
issue_valid  input  1  new instruction offered
issue_ready  output  1  at least one free entry (from registered state)
issue_alu_op  input  5  ALU opcode (`ADD … `BEQ macros)
issue_vj  input  32  operand 1 value, valid when issue_qj_valid=0
issue_qj_valid  input  1  operand 1 waits on tag issue_qj
issue_qj  input  TAG_W  producer tag, operand 1
issue_vk  input  32  operand 2 value
issue_qk_valid  input  1  operand 2 waits on tag issue_qk
issue_qk  input  TAG_W  producer tag, operand 2
issue_dest  input  TAG_W  destination ROB tag
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB tag
cdb_value  input  32  CDB value
alu_op1  output  32  to ALU op1
alu_op2  output  32  to ALU op2
alu_op  output  5  to ALU alu_op
alu_result  input  32  from ALU result
alu_fire  output  1  dispatch this cycle
out_valid  output  1  result broadcast valid
out_tag  output  TAG_W  result tag
out_value  output  32  result value

Behaviour:
- Reset (rst_in=0, async): all entries not busy; out_valid=0, out_tag=0, out_value=0; hence issue_ready=1, alu_fire=0, alu_op1/alu_op2/alu_op=0.
- Entry fields: busy, op, vj, qj_valid, qj, vk, qk_valid, qk, dest.
- Ready entry: busy && !qj_valid && !qk_valid.
- Dispatch (combinational):
  - Select the lowest-index ready entry; alu_fire=1; drive alu_op1=vj, alu_op2=vk, alu_op=op.
  - If no entry is ready, alu_fire=0 and all three ALU outputs are 0.
- Posedge, rdy_in=1, flush_in=0:
  - If alu_fire: out_valid<=1, out_tag<=dest, out_value<=alu_result; clear that entry's busy. Otherwise out_valid<=0.
  - Branch opcodes broadcast alu_result unmodified (0/1).
  - Result latency is exactly 1 cycle from dispatch.
  - Issue: if issue_valid && issue_ready, write the lowest-index entry not busy at the start of the cycle.
  - A slot freed by dispatch in this same cycle is not reusable until the next cycle.
  - issue_valid while issue_ready=0 is ignored; the issuer must hold.
- CDB capture:
  - For every busy entry with qj_valid && qj==cdb_tag (likewise qk) and cdb_valid: vj<=cdb_value, qj_valid<=0.
  - The entry becomes eligible for dispatch the following cycle.
- Issue bypass: if an issued operand waits on a tag equal to cdb_tag with cdb_valid in the same cycle, store cdb_value with q*_valid=0.
- Both operands may be captured from one broadcast when qj==qk.
- Dispatch and capture in the same cycle target disjoint entries; a dispatching entry is already ready.
- Full: issue_ready=0 when all RS_SIZE entries are busy.
- Empty: alu_fire=0, out_valid drops to 0 on the next edge.
- Flush (sync, priority over everything at rdy_in=1): all busy<=0, out_valid<=0; a concurrent issue is dropped.
- rdy_in=0: no register changes, including out_valid; the combinational outputs still reflect the held state.
- Reset mid-operation discards all entries and any pending broadcast immediately.

Test Plan:
- Issue `ADD vj=5, vk=7, both ready, dest=3 at cycle 0 -> alu_fire=1 in cycle 1; out_valid=1, out_tag=3, out_value=12 in cycle 2; issue_ready stays 1.
- Issue `SUB with qj_valid=1, qj=6, vk=10, dest=2; three cycles later cdb_valid=1, cdb_tag=6, cdb_value=25 -> dispatch on the cycle after capture; out_value=15, out_tag=2.
- Issue with qj=qk=9 in the same cycle as CDB tag 9, value 4, op `ADD -> operands bypassed, dispatched next cycle; out_value=8.
- Fill 4 entries all waiting on tag 1 -> issue_ready=0; a fifth issue is ignored. Broadcast tag 1 -> entries dispatch in index order 0,1,2,3 on consecutive cycles with 4 consecutive out_valid pulses.
- Hold rdy_in=0 for 3 cycles with one ready entry -> alu_op1/op2 stay driven, no state change, out_valid unchanged. Raise rdy_in -> result emitted once.
- Assert flush_in with 3 busy entries plus a pending broadcast -> the next edge gives out_valid=0, issue_ready=1, alu_fire=0. Separately, pull rst_in low mid-cycle -> outputs reset without waiting for a clock edge.
